// File: rtl/fifo_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_control_pkg
//  Description : Shared defaults for the FIFO control block and the RAM
//                (memoria) instance that sits beside it. Also defines the
//                per-cycle operation encoding used by the occupancy counter.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_control_pkg;

  // Defaults shared by the controller and the memoria instance.
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_AF_THRESH  = 6;
  localparam int DEF_AE_THRESH  = 2;

  // Accepted operations in one cycle: {write accepted, read accepted}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage : fifo_control_pkg
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ptr
//  Description : Wrapping address register. Advances by one on inc and
//                wraps from DEPTH-1 back to 0, so it never leaves 0..DEPTH-1.
//  Ports       : clk   - clock, rising edge
//                reset - synchronous active-high reset (ptr -> 0)
//                inc   - advance the pointer this cycle
//                ptr   - registered pointer value
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_ptr
  import fifo_control_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr
);

  localparam logic [ADDR_WIDTH-1:0] C_LAST = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      ptr_d = (ptr_q == C_LAST) ? '0 : ptr_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule : fifo_ptr
`default_nettype wire

// File: rtl/fifo_control.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_control
//  Description : Control half of a FIFO built around the registered-output
//                RAM memoria. Generates RAM addresses and strobes, tracks
//                occupancy, decodes status flags and keeps sticky error bits.
//  Ports       : clk, reset            - clock / synchronous active-high reset
//                push, pop             - producer / consumer requests
//                wr_ptr, rd_ptr        - RAM write / read addresses
//                write_enable,
//                read_enable           - RAM strobes (accepted requests)
//                fifo_count            - occupancy 0..DEPTH
//                full, empty,
//                almost_full,
//                almost_empty          - status flags decoded from fifo_count
//                data_valid            - RAM output holds the popped word
//                overflow, underflow   - sticky error flags
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_control
  import fifo_control_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_THRESH  = DEF_AF_THRESH,
  parameter int AE_THRESH  = DEF_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic                  write_enable,
  output logic                  read_enable,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  data_valid,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int              C_CW    = ADDR_WIDTH + 1;
  localparam logic [C_CW-1:0] C_DEPTH = C_CW'(DEPTH);
  localparam logic [C_CW-1:0] C_AF    = C_CW'(AF_THRESH);
  localparam logic [C_CW-1:0] C_AE    = C_CW'(AE_THRESH);

  logic [C_CW-1:0] count_q;
  logic [C_CW-1:0] count_d;
  logic            data_valid_q;
  logic            overflow_q;
  logic            underflow_q;
  fifo_op_e        op;

  // Flags decode the registered count directly, so they never lag it.
  assign full         = (count_q == C_DEPTH);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= C_AF);
  assign almost_empty = (count_q <= C_AE);

  // Accept decisions use only the registered flags: a same-cycle pop cannot
  // make room for a push when full, nor a push feed a pop when empty.
  assign write_enable = push & ~full  & ~reset;
  assign read_enable  = pop  & ~empty & ~reset;

  assign op = fifo_op_e'({write_enable, read_enable});

  always_comb begin
    count_d = count_q;
    case (op)
      OP_WR:   count_d = count_q + C_CW'(1);
      OP_RD:   count_d = count_q - C_CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      // The RAM registers its output, so the word is valid one cycle later.
      data_valid_q <= read_enable;
      overflow_q   <= overflow_q  | (push & full);
      underflow_q  <= underflow_q | (pop & empty);
    end
  end

  fifo_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (write_enable),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (read_enable),
    .ptr   (rd_ptr)
  );

  assign fifo_count = count_q;
  assign data_valid = data_valid_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule : fifo_control
`default_nettype wire
